// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_ctrl
//  Brief    : VGA 640x480@60 Hz timing generator and output stage. Produces
//             pixel coordinates for the renderer, blanks the returned colour
//             outside the visible area and delays hsync/vsync so that they
//             line up with the renderer's pipeline latency.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int RGB_LAT  = 1     // renderer latency, 0..4
) (
   input  logic       vga_clk,
   input  logic       rst_n,
   input  logic [2:0] rgb_in,
   output logic [9:0] posx,
   output logic [9:0] posy,
   output logic       video_on,
   output logic       frame_tick,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb_out
);

   localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // 10-bit copies of the timing boundaries so every compare is width-matched
   localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
   localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
   localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0] hcnt;
   logic [9:0] vcnt;
   logic       hs_raw;
   logic       vs_raw;

   // {hsync active, vsync active, video_on} before and after the delay line
   logic [2:0] raw_bus;
   logic [2:0] dly_bus;

   // Free-running pixel/line counters; the line counter advances on pixel wrap
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (hcnt == H_LAST) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
      end else begin
         hcnt <= hcnt + 10'd1;
      end
   end

   // Undelayed decode of the current counter position
   always_comb begin
      video_on   = (hcnt < H_VIS) && (vcnt < V_VIS);
      hs_raw     = (hcnt >= HS_BEG) && (hcnt < HS_END);
      vs_raw     = (vcnt >= VS_BEG) && (vcnt < VS_END);
      frame_tick = (hcnt == 10'd0) && (vcnt == V_VIS);
      raw_bus    = {hs_raw, vs_raw, video_on};
   end

   assign posx = hcnt;
   assign posy = vcnt;

   generate
      if (RGB_LAT == 0) begin : g_no_delay
         // Renderer is combinational: only the output register remains
         assign dly_bus = raw_bus;
      end else begin : g_delay
         logic [2:0] stage [RGB_LAT];

         // Delay line matching the renderer latency; cleared to "inactive"
         // so a reset never lets a stale sync or colour escape afterwards
         always_ff @(posedge vga_clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < RGB_LAT; i++) begin
                  stage[i] <= 3'b000;
               end
            end else begin
               stage[0] <= raw_bus;
               for (int i = 1; i < RGB_LAT; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dly_bus = stage[RGB_LAT-1];
      end
   endgenerate

   // Output register: active-low syncs and blanked colour toward the DAC
   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         rgb_out <= 3'b000;
      end else begin
         hsync   <= ~dly_bus[2];
         vsync   <= ~dly_bus[1];
         rgb_out <= dly_bus[0] ? rgb_in : 3'b000;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_ctrl
//  Brief    : Self-checking bench for vga_timing_ctrl. Four instances:
//             0 = 640x480 RGB_LAT=1, 1 = 640x480 RGB_LAT=2 with echo renderer,
//             2 = reduced 32x15 timing RGB_LAT=1, 3 = reduced timing RGB_LAT=0.
//             Expected output changes are queued per instance/signal; a
//             monitor pops and compares whenever an output changes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] white = 3'b111;
   logic [2:0] echo_rgb;
   logic       rz1 = 1'b0;
   logic       rz2 = 1'b0;

   logic [9:0] px   [4];
   logic [9:0] py   [4];
   logic       vo   [4];
   logic       ft   [4];
   logic       hs   [4];
   logic       vs   [4];
   logic [2:0] rgbo [4];

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   ev_t evq [20][$];
   int  prev [4][5];
   int  hs_fall[$];
   int  hs_rise[$];
   int  vs_fall[$];
   int  vs_rise[$];
   int  ft_rise[$];
   int  rgb0_hi, rgb1_hi, rgb2_blank;

   string sname [5] = '{"hsync", "vsync", "rgb_out", "frame_tick", "posy"};

   always #20 clk = ~clk;

   vga_timing_ctrl #(.RGB_LAT(1)) u_d1 (
      .vga_clk(clk), .rst_n(rst_n), .rgb_in(white),
      .posx(px[0]), .posy(py[0]), .video_on(vo[0]), .frame_tick(ft[0]),
      .hsync(hs[0]), .vsync(vs[0]), .rgb_out(rgbo[0]));

   vga_timing_ctrl #(.RGB_LAT(2)) u_d2 (
      .vga_clk(clk), .rst_n(rst_n), .rgb_in(echo_rgb),
      .posx(px[1]), .posy(py[1]), .video_on(vo[1]), .frame_tick(ft[1]),
      .hsync(hs[1]), .vsync(vs[1]), .rgb_out(rgbo[1]));

   vga_timing_ctrl #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .RGB_LAT(1)) u_s1 (
      .vga_clk(clk), .rst_n(rst_n), .rgb_in(white),
      .posx(px[2]), .posy(py[2]), .video_on(vo[2]), .frame_tick(ft[2]),
      .hsync(hs[2]), .vsync(vs[2]), .rgb_out(rgbo[2]));

   vga_timing_ctrl #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                     .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
                     .RGB_LAT(0)) u_s0 (
      .vga_clk(clk), .rst_n(rst_n), .rgb_in(white),
      .posx(px[3]), .posy(py[3]), .video_on(vo[3]), .frame_tick(ft[3]),
      .hsync(hs[3]), .vsync(vs[3]), .rgb_out(rgbo[3]));

   // Model renderer for instance 1: white exactly when posx was 0, two cycles late
   always @(posedge clk) begin
      rz1 <= (px[1] == 10'd0);
      rz2 <= rz1;
   end
   assign echo_rgb = rz2 ? 3'b111 : 3'b000;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int get_obs(input int i, input int s);
      case (s)
         0:       return int'(hs[i]);
         1:       return int'(vs[i]);
         2:       return int'(rgbo[i]);
         3:       return int'(ft[i]);
         default: return int'(py[i]);
      endcase
   endfunction

   task automatic push(input int i, input int s, input int c, input int v, input int w);
      ev_t e;
      e.cyc = c;
      e.val = v;
      if (c < w) evq[i*5+s].push_back(e);
   endtask

   // Expected output changes for one instance over a window of w cycles after
   // release. hs0/hs1 and vs0/vs1 are first active / first inactive positions;
   // lat is the renderer latency; echo selects the single-pixel echo pattern.
   task automatic push_timing(input int i, input int ht, input int ha, input int hs0,
                              input int hs1, input int vt, input int va, input int vs0,
                              input int vs1, input int lat, input bit echo, input int w);
      int l, v, b;
      l = lat + 1;
      for (int j = 0; j * ht < w; j++) begin
         v = j % vt;
         b = j * ht;
         if (j > 0) push(i, 4, b, v, w);
         push(i, 0, b + hs0 + l, 0, w);
         push(i, 0, b + hs1 + l, 1, w);
         if (v == vs0) push(i, 1, b + l, 0, w);
         if (v == vs1) push(i, 1, b + l, 1, w);
         if (v < va) begin
            push(i, 2, b + l, 7, w);
            push(i, 2, echo ? b + l + 1 : b + ha + l, 0, w);
         end
         if (v == va) begin
            push(i, 3, b, 1, w);
            push(i, 3, b + 1, 0, w);
         end
      end
   endtask

   task automatic arm(input int w);
      for (int k = 0; k < 20; k++) evq[k].delete();
      for (int i = 0; i < 4; i++) begin
         prev[i][0] = 1; prev[i][1] = 1; prev[i][2] = 0; prev[i][3] = 0; prev[i][4] = 0;
      end
      hs_fall.delete(); hs_rise.delete(); vs_fall.delete(); vs_rise.delete();
      ft_rise.delete();
      rgb0_hi = 0; rgb1_hi = 0; rgb2_blank = 0;
      cyc = 0;
      push_timing(0, 800, 640, 656, 752, 525, 480, 490, 492, 1, 1'b0, w);
      push_timing(1, 800, 640, 656, 752, 525, 480, 490, 492, 2, 1'b1, w);
      push_timing(2, 32, 16, 20, 26, 15, 8, 10, 12, 1, 1'b0, w);
      push_timing(3, 32, 16, 20, 26, 15, 8, 10, 12, 0, 1'b0, w);
   endtask

   task automatic run_window(input int w);
      @(negedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (w - 1) @(negedge clk);
      @(posedge clk);
      mon_en = 1'b0;
      for (int k = 0; k < 20; k++)
         check($sformatf("inst%0d %s missing events", k / 5, sname[k % 5]), evq[k].size(), 0);
   endtask

   // Monitor: every output change is matched against the next queued event
   always @(negedge clk) begin
      if (mon_en) begin
         cyc++;
         for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 5; s++) begin
               int v;
               ev_t e;
               v = get_obs(i, s);
               if (v != prev[i][s]) begin
                  if (evq[i*5+s].size() == 0) begin
                     tests++;
                     failed++;
                     $display("FAIL inst%0d %s unexpected change: got %0d at cycle %0d, expected no change",
                              i, sname[s], v, cyc);
                  end else begin
                     e = evq[i*5+s].pop_front();
                     check($sformatf("inst%0d %s change cycle", i, sname[s]), cyc, e.cyc);
                     check($sformatf("inst%0d %s value", i, sname[s]), v, e.val);
                  end
                  if (i == 0 && s == 0) begin
                     if (v == 0) hs_fall.push_back(cyc); else hs_rise.push_back(cyc);
                  end
                  if (i == 2 && s == 1) begin
                     if (v == 0) vs_fall.push_back(cyc); else vs_rise.push_back(cyc);
                  end
                  if (i == 2 && s == 3 && v == 1) ft_rise.push_back(cyc);
                  prev[i][s] = v;
               end
            end
         end
         if (cyc <= 800 && rgbo[0] == 3'd7) rgb0_hi++;
         if (cyc <= 800 && rgbo[1] == 3'd7) rgb1_hi++;
         if (cyc >= 258 && cyc < 482 && rgbo[2] != 3'd0) rgb2_blank++;
      end
   end

   initial begin
      bit found;

      // Reset held over 10 edges
      rst_n = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("reset inst%0d posx", i), int'(px[i]), 0);
         check($sformatf("reset inst%0d posy", i), int'(py[i]), 0);
         check($sformatf("reset inst%0d video_on", i), int'(vo[i]), 1);
         check($sformatf("reset inst%0d frame_tick", i), int'(ft[i]), 0);
         check($sformatf("reset inst%0d hsync", i), int'(hs[i]), 1);
         check($sformatf("reset inst%0d vsync", i), int'(vs[i]), 1);
         check($sformatf("reset inst%0d rgb_out", i), int'(rgbo[i]), 0);
      end

      // Line, frame, blanking and alignment timing from release
      arm(2600);
      run_window(2600);
      check("d1 hsync fall count", hs_fall.size(), 3);
      check("d1 hsync rise count", hs_rise.size(), 3);
      if (hs_fall.size() >= 2 && hs_rise.size() >= 1) begin
         check("d1 first hsync fall", hs_fall[0], 658);
         check("d1 hsync low width", hs_rise[0] - hs_fall[0], 96);
         check("d1 line period", hs_fall[1] - hs_fall[0], 800);
      end
      check("small vsync fall count", vs_fall.size(), 5);
      if (vs_fall.size() >= 1 && vs_rise.size() >= 1) begin
         check("small first vsync fall", vs_fall[0], 322);
         check("small vsync low width", vs_rise[0] - vs_fall[0], 64);
      end
      check("small frame_tick count", ft_rise.size(), 5);
      if (ft_rise.size() >= 2) begin
         check("small first frame_tick", ft_rise[0], 256);
         check("small frame period", ft_rise[1] - ft_rise[0], 480);
      end
      check("d1 white cycles line 0", rgb0_hi, 640);
      check("d2 echo white cycles line 0", rgb1_hi, 1);
      check("small colour in vertical blank", rgb2_blank, 0);

      // Reset in the middle of hsync and vsync low on the reduced instance
      found = 1'b0;
      for (int n = 0; n < 1000 && !found; n++) begin
         @(negedge clk);
         if (px[2] == 10'd24 && py[2] == 10'd10) found = 1'b1;
      end
      check("mid-reset position reached", int'(found), 1);
      check("small hsync low before reset", int'(hs[2]), 0);
      check("small vsync low before reset", int'(vs[2]), 0);
      #1;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("async reset inst%0d hsync", i), int'(hs[i]), 1);
         check($sformatf("async reset inst%0d vsync", i), int'(vs[i]), 1);
         check($sformatf("async reset inst%0d rgb_out", i), int'(rgbo[i]), 0);
         check($sformatf("async reset inst%0d posx", i), int'(px[i]), 0);
      end
      repeat (5) @(posedge clk);
      arm(700);
      run_window(700);
      check("post-reset d1 hsync fall count", hs_fall.size(), 1);
      if (hs_fall.size() >= 1)
         check("post-reset d1 first hsync fall", hs_fall[0], 658);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
